// File: rtl/axi_stream_transmitter.sv
// AXI-Stream master: input FIFO, registered beat, TKEEP/TUSER from byte count, per-packet TID.
// Define AXIS_TX_MAX_BEATS_EN to force TLAST after MAX_BEATS beats and flag it on err_trunc.
module axi_stream_transmitter #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DEST       = 0,
    parameter int MAX_BEATS  = 64
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [3:0]              in_nbytes,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   TDATA,
    output logic                    TVALID,
    input  logic                    TREADY,
    output logic                    TLAST,
    output logic [DATA_WIDTH/8-1:0] TKEEP,
    output logic [DATA_WIDTH/8-1:0] TSTRB,
    output logic [1:0]              TID,
    output logic                    TDEST,
    output logic [3:0]              TUSER,
    output logic                    busy,
    output logic                    pkt_done,
    output logic                    err_trunc
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 5;
    localparam logic [3:0] FULL_NB = 4'(NB);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_LAST} state_t;

    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 64) begin : g_chk_dw
        $error("DATA_WIDTH must be a multiple of 8 in 8..64");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (MAX_BEATS < 1) begin : g_chk_beats
        $error("MAX_BEATS must be at least 1");
    end

    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [NB-1:0]         r_tkeep;
    logic [3:0]            r_tuser;
    logic [1:0]            r_tid;
    state_t                r_state;
    state_t                w_next;

    logic                  w_wr;
    logic                  w_load;
    logic                  w_hs;
    logic                  w_empty;
    logic                  w_full;
    logic [3:0]            w_nb_in;
    logic [DATA_WIDTH-1:0] w_hd_data;
    logic                  w_hd_last;
    logic [3:0]            w_hd_nb;
    logic                  w_force;
    logic                  w_last_eff;
    logic [NB-1:0]         w_keep;
    logic                  w_open;
    logic                  w_pkt_done;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign in_ready = !w_full;
    assign w_wr     = in_valid && !w_full;
    assign w_hs     = r_tvalid && TREADY;
    assign w_load   = (!r_tvalid || TREADY) && !w_empty;

    assign {w_hd_data, w_hd_last, w_hd_nb} = r_mem[r_rptr];
    assign w_last_eff = w_hd_last || w_force;

    // Only a last word may be partial; out-of-range counts mean a full word.
    always_comb begin
        w_nb_in = FULL_NB;
        if (in_last && in_nbytes != 4'd0 && in_nbytes <= FULL_NB)
            w_nb_in = in_nbytes;
    end

    always_comb begin
        w_keep = '0;
        for (int i = 0; i < NB; i++)
            w_keep[i] = (4'(i) < w_hd_nb);
    end

    always_ff @(posedge ACLK) begin
        if (w_wr)
            r_mem[r_wptr] <= {in_data, in_last, w_nb_in};
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_load)
                r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tuser  <= '0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tlast  <= w_last_eff;
            r_tdata  <= w_hd_data;
            r_tkeep  <= w_keep;
            r_tuser  <= w_hd_nb;
        end else if (w_hs) begin
            r_tvalid <= 1'b0;
        end
    end

`ifdef AXIS_TX_MAX_BEATS_EN
    localparam int BW = $clog2(MAX_BEATS + 1);
    logic [BW-1:0] r_beats;
    logic          r_trunc;

    assign w_force = !w_hd_last && (r_beats == BW'(MAX_BEATS - 1));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_beats <= '0;
            r_trunc <= 1'b0;
        end else if (w_load) begin
            r_beats <= w_last_eff ? '0 : r_beats + 1'b1;
            r_trunc <= w_force;
        end
    end

    assign err_trunc = w_pkt_done && r_trunc;
`else
    assign w_force   = 1'b0;
    assign err_trunc = 1'b0;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_load) w_next = w_last_eff ? S_LAST : S_SEND;
            S_SEND: if (w_load && w_last_eff) w_next = S_LAST;
            S_LAST: if (w_hs) begin
                if (w_load)
                    w_next = w_last_eff ? S_LAST : S_SEND;
                else
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_open     = 1'b0;
        w_pkt_done = 1'b0;
        case (r_state)
            S_SEND: w_open = 1'b1;
            S_LAST: begin
                w_open     = 1'b1;
                w_pkt_done = w_hs;
            end
            default: w_open = 1'b0;
        endcase
    end

    // TID only moves on the closing handshake, so it is stable within a packet.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            r_tid <= 2'd0;
        else if (w_pkt_done)
            r_tid <= r_tid + 2'd1;
    end

    assign TDATA    = r_tdata;
    assign TVALID   = r_tvalid;
    assign TLAST    = r_tlast;
    assign TKEEP    = r_tkeep;
    assign TSTRB    = r_tkeep;
    assign TUSER    = r_tuser;
    assign TID      = r_tid;
    assign TDEST    = 1'(DEST);
    assign pkt_done = w_pkt_done;
    assign busy     = w_open || !w_empty || r_tvalid;

endmodule

// File: tb/tb_axi_stream_transmitter.sv
// Directed, table-driven bench for axi_stream_transmitter (16-bit data, depth-4 FIFO).
// Beat-limit packet is exercised only when AXIS_TX_MAX_BEATS_EN is defined.
module tb_axi_stream_transmitter;
    localparam int DW = 16;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [3:0]    in_nbytes = '0;
    logic          in_ready;
    logic [DW-1:0] TDATA;
    logic          TVALID;
    logic          TREADY = 1'b0;
    logic          TLAST;
    logic [1:0]    TKEEP;
    logic [1:0]    TSTRB;
    logic [1:0]    TID;
    logic          TDEST;
    logic [3:0]    TUSER;
    logic          busy;
    logic          pkt_done;
    logic          err_trunc;

    axi_stream_transmitter #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(4), .DEST(0), .MAX_BEATS(4)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_nbytes(in_nbytes), .in_ready(in_ready),
        .TDATA(TDATA), .TVALID(TVALID), .TREADY(TREADY), .TLAST(TLAST),
        .TKEEP(TKEEP), .TSTRB(TSTRB), .TID(TID), .TDEST(TDEST),
        .TUSER(TUSER), .busy(busy), .pkt_done(pkt_done), .err_trunc(err_trunc)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [3:0]  nb;
        logic        xlast;
        logic [1:0]  xkeep;
        logic [3:0]  xuser;
        logic [1:0]  xtid;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [1:0]  keep;
        logic [1:0]  strb;
        logic [3:0]  user;
        logic [1:0]  tid;
        int          cyc;
    } beat_t;

    vec_t        vec [25];
    beat_t       beats [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          pd_cnt = 0;
    int          et_cnt = 0;
    int          et_total = 0;
    bit          tr_toggle = 1'b0;
    int          tr_idx = 0;
    bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        hold = 1'b0;
    logic [31:0] saved = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] d, input logic l, input logic [3:0] nb,
                                input logic xl, input logic [1:0] xk, input logic [3:0] xu,
                                input logic [1:0] xt);
        vec_t v;
        v.data = d; v.last = l; v.nb = nb;
        v.xlast = xl; v.xkeep = xk; v.xuser = xu; v.xtid = xt;
        return v;
    endfunction

    always @(posedge ACLK) cyc <= cyc + 1;

    initial forever begin
        @(negedge ACLK);
        if (ARESET) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_tvalid", 32'(TVALID), 32'd1);
                chk("hold_tbeat", {7'd0, TDATA, TLAST, TKEEP, TUSER, TID}, saved);
            end
            if (TVALID && TREADY)
                beats.push_back('{TDATA, TLAST, TKEEP, TSTRB, TUSER, TID, cyc});
            if (pkt_done) pd_cnt++;
            if (err_trunc) begin
                et_cnt++;
                et_total++;
            end
            hold = TVALID && !TREADY;
            saved = {7'd0, TDATA, TLAST, TKEEP, TUSER, TID};
        end
    end

    initial forever begin
        @(posedge ACLK);
        #1;
        if (tr_toggle) begin
            TREADY = pat[tr_idx % 4];
            tr_idx++;
        end
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_word(input logic [15:0] d, input logic l, input logic [3:0] nb);
        int t;
        t = 0;
        in_data = d; in_last = l; in_nbytes = nb; in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            step();
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int first, input int n);
        for (int i = first; i < first + n; i++)
            send_word(vec[i].data, vec[i].last, vec[i].nb);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || in_valid) && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got busy=%0b expected 0 within 200 cycles", busy);
        end
    endtask

    task automatic check_beats(input int first, input int n);
        beat_t b;
        chk($sformatf("beat_count_from_%0d", first), 32'(beats.size()), 32'(n));
        for (int i = first; i < first + n; i++) begin
            if (beats.size() == 0) break;
            b = beats.pop_front();
            chk($sformatf("b%0d_tdata", i), 32'(b.data), 32'(vec[i].data));
            chk($sformatf("b%0d_tlast", i), 32'(b.last), 32'(vec[i].xlast));
            chk($sformatf("b%0d_tkeep", i), 32'(b.keep), 32'(vec[i].xkeep));
            chk($sformatf("b%0d_tstrb", i), 32'(b.strb), 32'(vec[i].xkeep));
            chk($sformatf("b%0d_tuser", i), 32'(b.user), 32'(vec[i].xuser));
            chk($sformatf("b%0d_tid", i), 32'(b.tid), 32'(vec[i].xtid));
        end
        beats.delete();
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        in_valid = 1'b0;
        TREADY = 1'b0;
        repeat (2) step();
        ARESET = 1'b0;
        beats.delete();
        pd_cnt = 0;
        et_cnt = 0;
    endtask

    initial begin
        //            data     last nb     xlast xkeep  xuser xtid
        vec[0]  = mk(16'h1111, 1'b0, 4'd3, 1'b0, 2'b11, 4'd2, 2'd0);
        vec[1]  = mk(16'h2222, 1'b0, 4'd2, 1'b0, 2'b11, 4'd2, 2'd0);
        vec[2]  = mk(16'h3333, 1'b1, 4'd1, 1'b1, 2'b01, 4'd1, 2'd0);
        vec[3]  = mk(16'h1111, 1'b0, 4'd2, 1'b0, 2'b11, 4'd2, 2'd1);
        vec[4]  = mk(16'h2222, 1'b0, 4'd0, 1'b0, 2'b11, 4'd2, 2'd1);
        vec[5]  = mk(16'h3333, 1'b1, 4'd1, 1'b1, 2'b01, 4'd1, 2'd1);
        vec[6]  = mk(16'hA001, 1'b0, 4'd2, 1'b0, 2'b11, 4'd2, 2'd2);
        vec[7]  = mk(16'hA002, 1'b0, 4'd2, 1'b0, 2'b11, 4'd2, 2'd2);
        vec[8]  = mk(16'hA003, 1'b0, 4'd2, 1'b0, 2'b11, 4'd2, 2'd2);
        vec[9]  = mk(16'hA004, 1'b0, 4'd2, 1'b0, 2'b11, 4'd2, 2'd2);
        vec[10] = mk(16'hA005, 1'b1, 4'd0, 1'b1, 2'b11, 4'd2, 2'd2);
        vec[11] = mk(16'h0B01, 1'b1, 4'd1, 1'b1, 2'b01, 4'd1, 2'd0);
        vec[12] = mk(16'h0B02, 1'b1, 4'd2, 1'b1, 2'b11, 4'd2, 2'd1);
        vec[13] = mk(16'h0B03, 1'b1, 4'd7, 1'b1, 2'b11, 4'd2, 2'd2);
        vec[14] = mk(16'h0B04, 1'b1, 4'd0, 1'b1, 2'b11, 4'd2, 2'd3);
        vec[15] = mk(16'h0B05, 1'b1, 4'd1, 1'b1, 2'b01, 4'd1, 2'd0);
        vec[16] = mk(16'hD001, 1'b0, 4'd2, 1'b0, 2'b11, 4'd2, 2'd0);
        vec[17] = mk(16'hD002, 1'b1, 4'd2, 1'b1, 2'b11, 4'd2, 2'd0);
        vec[18] = mk(16'hC001, 1'b0, 4'd2, 1'b0, 2'b11, 4'd2, 2'd0);
        vec[19] = mk(16'hC002, 1'b0, 4'd2, 1'b0, 2'b11, 4'd2, 2'd0);
        vec[20] = mk(16'hC003, 1'b0, 4'd2, 1'b0, 2'b11, 4'd2, 2'd0);
        vec[21] = mk(16'hC004, 1'b0, 4'd2, 1'b1, 2'b11, 4'd2, 2'd0);
        vec[22] = mk(16'hC005, 1'b0, 4'd2, 1'b0, 2'b11, 4'd2, 2'd1);
        vec[23] = mk(16'hC006, 1'b0, 4'd2, 1'b0, 2'b11, 4'd2, 2'd1);
        vec[24] = mk(16'hC007, 1'b1, 4'd1, 1'b1, 2'b01, 4'd1, 2'd1);

        repeat (3) step();
        ARESET = 1'b0;
        #1;
        chk("rst_tvalid", 32'(TVALID), 32'd0);
        chk("rst_tlast", 32'(TLAST), 32'd0);
        chk("rst_tdata", 32'(TDATA), 32'd0);
        chk("rst_tkeep", 32'(TKEEP), 32'd0);
        chk("rst_tstrb", 32'(TSTRB), 32'd0);
        chk("rst_tuser", 32'(TUSER), 32'd0);
        chk("rst_tid", 32'(TID), 32'd0);
        chk("rst_tdest", 32'(TDEST), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pkt_done", 32'(pkt_done), 32'd0);
        chk("rst_err_trunc", 32'(err_trunc), 32'd0);

        // 3-word packet, TREADY high, with first-beat latency
        TREADY = 1'b1;
        send_vec(0, 1);
        chk("lat_tvalid_after_write", 32'(TVALID), 32'd0);
        send_vec(1, 1);
        chk("lat_tvalid_next_edge", 32'(TVALID), 32'd1);
        chk("lat_tdata_next_edge", 32'(TDATA), 32'h1111);
        send_vec(2, 1);
        wait_idle();
        check_beats(0, 3);
        chk("t1_pkt_done_cnt", 32'(pd_cnt), 32'd1);

        // same packet under TREADY back-pressure pattern
        pd_cnt = 0;
        tr_toggle = 1'b1;
        send_vec(3, 3);
        wait_idle();
        tr_toggle = 1'b0;
        TREADY = 1'b1;
        check_beats(3, 3);
        chk("t2_pkt_done_cnt", 32'(pd_cnt), 32'd1);

        // fill FIFO plus output register with TREADY low
        pd_cnt = 0;
        TREADY = 1'b0;
        send_vec(6, 5);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_tvalid", 32'(TVALID), 32'd1);
        chk("full_tdata", 32'(TDATA), 32'hA001);
        chk("full_busy", 32'(busy), 32'd1);
        repeat (3) step();
        chk("full_in_ready_held", 32'(in_ready), 32'd0);
        chk("full_no_beats", 32'(beats.size()), 32'd0);
        TREADY = 1'b1;
        wait_idle();
        check_beats(6, 5);
        chk("t3_pkt_done_cnt", 32'(pd_cnt), 32'd1);

        // back-to-back single-beat packets, TID wrap
        do_reset();
        TREADY = 1'b1;
        send_vec(11, 5);
        wait_idle();
        if (beats.size() >= 5) begin
            for (int i = 1; i < 5; i++)
                chk($sformatf("b2b_gap_%0d", i), 32'(beats[i].cyc - beats[i-1].cyc), 32'd1);
        end
        check_beats(11, 5);
        chk("t4_pkt_done_cnt", 32'(pd_cnt), 32'd5);

        // reset with a packet half buffered
        do_reset();
        send_word(16'hE001, 1'b0, 4'd2);
        send_word(16'hE002, 1'b0, 4'd2);
        send_word(16'hE003, 1'b0, 4'd2);
        chk("mid_tvalid", 32'(TVALID), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        ARESET = 1'b1;
        #1;
        chk("arst_tvalid", 32'(TVALID), 32'd0);
        chk("arst_tlast", 32'(TLAST), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) step();
        ARESET = 1'b0;
        beats.delete();
        pd_cnt = 0;
        TREADY = 1'b1;
        send_vec(16, 2);
        wait_idle();
        check_beats(16, 2);
        chk("t5_pkt_done_cnt", 32'(pd_cnt), 32'd1);

`ifdef AXIS_TX_MAX_BEATS_EN
        do_reset();
        TREADY = 1'b1;
        send_vec(18, 7);
        wait_idle();
        check_beats(18, 7);
        chk("trunc_pkt_done_cnt", 32'(pd_cnt), 32'd2);
        chk("trunc_err_cnt", 32'(et_cnt), 32'd1);
`else
        chk("err_trunc_never", 32'(et_total), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion before 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule
